key_led: RTL and testbench
==========================

// Module: key_led
// PURPOSE
//  Two-key LED pattern controller for the board LED demo.
//  - Samples two active-low push-buttons and drives two LEDs.
//  - key0 held: LEDs alternate ("flow"). key1 held: both LEDs blink together.
//  - No key held: both LEDs off. Pattern steps every CNT_MAX clock cycles.
//  - Sits directly between board pins and the LEDs.
// PARAMETERS
//  CNT_MAX  default 25'd25_000_000  clock cycles per pattern step (0.5 s at 50 MHz);
//           25 bits wide; benches override it with 25'd25 (500 ns at 20 ns clock)
// PORTS
//  sys_clk   in   1  system clock, single clock domain, rising edge
//  sys_rst   in   1  synchronous, active-high reset
//  key       in   2  push-buttons, active-low (0 = pressed), asynchronous to sys_clk
//  led       out  2  LED drive, active-high (1 = lit)
// BEHAVIOUR
//  Reset (sys_rst=1 at a clock edge)
//   - Synchronizers load 2'b11. Mode = IDLE. Step counter = 0. led = 2'b00.
//   - Reset asserted mid-pattern has the same effect on the next edge.
//  Input sampling
//   - Each key bit passes through a 2-FF synchronizer (ks1 -> ks2).
//   - No debounce filter is required.
//  Mode decode (from ks2)
//   - ks2[0]==0 -> FLOW. This takes priority, including when both keys are pressed.
//   - else ks2[1]==0 -> BLINK.
//   - else -> IDLE.
//   - Mode is registered. Whenever the decoded mode differs from the current mode:
//     load the new mode, clear the counter to 0, and load the initial pattern.
//  Initial patterns
//   - IDLE: 2'b00.
//   - FLOW: 2'b01.
//   - BLINK: 2'b11.
//  Latency
//   - A key edge at the pin appears on led at the 3rd rising edge after it:
//     ks1, then ks2, then mode/led.
//  Step counter
//   - Counts 0..CNT_MAX-1 and wraps to 0.
//   - tick = (cnt == CNT_MAX-1).
//   - In IDLE the counter is held at 0 and led stays at 2'b00.
//  Pattern update on tick (mode unchanged)
//   - FLOW: led <= {led[0], led[1]}, i.e. 01 -> 10 -> 01 ...
//   - BLINK: led <= ~led, i.e. 11 -> 00 -> 11 ...
//   - Each pattern therefore holds for exactly CNT_MAX cycles.
//  Simultaneous events
//   - A mode change and a tick in the same cycle: the mode change wins (initial pattern, cnt = 0).
//   - Reset overrides everything.
//  Width and wrap
//   - cnt is 25 bits, compared against CNT_MAX-1 only; it never exceeds CNT_MAX-1.
//   - CNT_MAX >= 2 is required.
//  led is a direct register output with no combinational path from key.
// STRUCTURE
//  Package key_led_pkg
//   - mode_t enum: IDLE, FLOW, BLINK.
//   - LED_OFF = 2'b00, FLOW_INIT = 2'b01, BLINK_INIT = 2'b11.
//  Sub-module key_sync
//   - Parameterised-width 2-FF synchronizer with reset value all-ones.
//   - Instantiated once for the 2-bit key bus.
//  Top level
//   - Mode register, step counter and LED register.
// TESTING (20 ns clock, CNT_MAX=25)
//  1. Reset held 200 ns, key=11 -> led=00 throughout; led stays 00 for 2000 ns after release.
//  2. key=10 -> led=01 on the 3rd edge after the change.
//     Then led=10 after 25 more cycles, and it alternates every 25 cycles (500 ns).
//  3. Release to key=11 -> led=00 within 3 edges; counter held at 0.
//  4. key=01 -> led=11 on the 3rd edge, then 00/11 toggling every 500 ns.
//     Release -> led=00.
//  5. key=00 -> FLOW behaviour (key0 priority).
//     Switch 00 -> 01 mid-step -> led=11 with the counter restarted.
//  6. Assert sys_rst for 1 cycle during FLOW -> led=00 at that edge.
//     With the key still held: led=01 three edges after sys_rst is released.

Source files
------------

// File: rtl/key_led_pkg.sv
// Shared types and constants for the two-key LED pattern controller.
package key_led_pkg;

    localparam int CNT_W = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLOW  = 2'd1,
        BLINK = 2'd2
    } mode_t;

    localparam logic [1:0] LED_OFF    = 2'b00;
    localparam logic [1:0] FLOW_INIT  = 2'b01;
    localparam logic [1:0] BLINK_INIT = 2'b11;

    // Pattern loaded whenever a mode is (re)entered.
    function automatic logic [1:0] init_pattern(input mode_t m);
        logic [1:0] p;
        p = LED_OFF;
        case (m)
            FLOW:    p = FLOW_INIT;
            BLINK:   p = BLINK_INIT;
            default: p = LED_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/key_led_if.sv
// Board-side bundle: raw active-low keys in, active-high LED drive out.
interface key_led_if;
    logic [1:0] key;
    logic [1:0] led;

    modport master (output key, input  led);
    modport slave  (input  key, output led);
endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for asynchronous inputs. Resets to all-ones so
// active-low buttons read as released while in reset.
module key_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ks1;
    logic [W-1:0] ks2;

    // ks1 catches the pin, ks2 gives the metastability settle cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ks1 <= '1;
            ks2 <= '1;
        end else begin
            ks1 <= d;
            ks2 <= ks1;
        end
    end

    assign q = ks2;

endmodule

// File: rtl/key_led.sv
// Two-key LED pattern controller: key0 held -> LEDs alternate, key1 held ->
// LEDs blink together, nothing held -> LEDs off. Pattern steps every CNT_MAX
// cycles. led comes straight from a register.
module key_led
    import key_led_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_MAX = 25'd25_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    key_led_if.slave   bus
);

    logic [1:0]       ks2;
    mode_t            mode_q, mode_d, mode_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       led_q, led_d;
    logic             tick;

    key_sync #(.W(2)) u_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (bus.key),
        .q   (ks2)
    );

    assign tick = (cnt_q == CNT_MAX - 1'b1);

    // Decode requested mode; key0 wins when both keys are pressed
    always_comb begin
        mode_dec = IDLE;
        if (!ks2[0])
            mode_dec = FLOW;
        else if (!ks2[1])
            mode_dec = BLINK;
    end

    // Next state: a mode change restarts the step and beats a same-cycle tick
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        if (mode_dec != mode_q) begin
            mode_d = mode_dec;
            cnt_d  = '0;
            led_d  = init_pattern(mode_dec);
        end else begin
            case (mode_q)
                FLOW, BLINK: begin
                    if (tick) begin
                        cnt_d = '0;
                        led_d = (mode_q == FLOW) ? {led_q[0], led_q[1]} : ~led_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                    led_d = LED_OFF;
                end
            endcase
        end
    end

    // State registers; reset overrides everything
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q <= IDLE;
            cnt_q  <= '0;
            led_q  <= LED_OFF;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
        end
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_key_led.sv
// Directed bench for key_led with CNT_MAX=25 on a 20 ns clock.
module tb_key_led;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    key_led_if kif ();

    key_led #(.CNT_MAX(25'd25)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (kif)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: led=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // advance n rising edges, then sit 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        kif.key = 2'b11;
        sys_rst = 1'b1;

        // 1: reset held 200 ns, then idle for 2000 ns
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("rst_hold", kif.led, 2'b00);
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("idle", kif.led, 2'b00);
        end

        // 2: key0 pressed -> flow, 3-edge latency, 25-cycle steps
        kif.key = 2'b10;
        step(2);  chk("flow_lat2", kif.led, 2'b00);
        step(1);  chk("flow_lat3", kif.led, 2'b01);
        step(24); chk("flow_hold0", kif.led, 2'b01);
        step(1);  chk("flow_step1", kif.led, 2'b10);
        step(24); chk("flow_hold1", kif.led, 2'b10);
        step(1);  chk("flow_step2", kif.led, 2'b01);
        step(25); chk("flow_step3", kif.led, 2'b10);

        // 3: release -> off, stays off
        kif.key = 2'b11;
        step(2);  chk("rel_lat2", kif.led, 2'b10);
        step(1);  chk("rel_lat3", kif.led, 2'b00);
        step(60); chk("rel_held", kif.led, 2'b00);

        // 4: key1 pressed -> blink together
        kif.key = 2'b01;
        step(2);  chk("blink_lat2", kif.led, 2'b00);
        step(1);  chk("blink_lat3", kif.led, 2'b11);
        step(24); chk("blink_hold0", kif.led, 2'b11);
        step(1);  chk("blink_step1", kif.led, 2'b00);
        step(25); chk("blink_step2", kif.led, 2'b11);
        step(25); chk("blink_step3", kif.led, 2'b00);
        kif.key = 2'b11;
        step(3);  chk("blink_rel", kif.led, 2'b00);

        // 5: both pressed -> flow; then drop key0 mid-step -> blink, counter restarts
        kif.key = 2'b00;
        step(3);  chk("both_flow", kif.led, 2'b01);
        step(25); chk("both_step", kif.led, 2'b10);
        step(10); chk("both_mid", kif.led, 2'b10);
        kif.key = 2'b01;
        step(2);  chk("sw_lat2", kif.led, 2'b10);
        step(1);  chk("sw_blink", kif.led, 2'b11);
        step(24); chk("sw_hold", kif.led, 2'b11);
        step(1);  chk("sw_step", kif.led, 2'b00);

        // 6: one-cycle reset during flow, key still held
        kif.key = 2'b10;
        step(3);  chk("pre_rst_flow", kif.led, 2'b01);
        step(5);
        sys_rst = 1'b1;
        step(1);  chk("mid_rst", kif.led, 2'b00);
        sys_rst = 1'b0;
        step(2);  chk("post_rst2", kif.led, 2'b00);
        step(1);  chk("post_rst3", kif.led, 2'b01);
        step(25); chk("post_rst_step", kif.led, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
